// File: rtl/ref_prep_pkg.sv
// rtl/ref_prep_pkg.sv - shared constants and state encoding for the intra reference prep block
package ref_prep_pkg;

    localparam int BIT_DEPTH   = 8;
    localparam int NUM_SAMPLES = 17;
    localparam int CNT_W       = 5;
    localparam int NUM_SIDE    = 8;

    localparam logic [BIT_DEPTH-1:0] DEFAULT_VAL = BIT_DEPTH'(1 << (BIT_DEPTH - 1));
    localparam logic [CNT_W-1:0]     LAST_IDX    = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SUBST = 3'd2,
        ST_FILT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/ref_filter3.sv
// rtl/ref_filter3.sv - combinational [1 2 1] rounding smoother for one reference sample
module ref_filter3
    import ref_prep_pkg::*;
(
    input  logic [BIT_DEPTH-1:0] i_a,
    input  logic [BIT_DEPTH-1:0] i_b,
    input  logic [BIT_DEPTH-1:0] i_c,
    output logic [BIT_DEPTH-1:0] o_f
);

    // Two guard bits hold the full 4x weighted sum; the result never exceeds the input range.
    logic [BIT_DEPTH+1:0] w_sum;

    assign w_sum = {2'b00, i_a} + {1'b0, i_b, 1'b0} + {2'b00, i_c} + (BIT_DEPTH+2)'(2);
    assign o_f   = BIT_DEPTH'(w_sum >> 2);

endmodule

// File: rtl/ref_sample_prep.sv
// rtl/ref_sample_prep.sv - serial neighbour capture, availability substitution and angle/planar reference sets
module ref_sample_prep
    import ref_prep_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 top_avail,
    input  logic                 left_avail,
    input  logic                 corner_avail,
    input  logic [BIT_DEPTH-1:0] pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 busy,
    output logic                 ref_valid,
    output logic [BIT_DEPTH-1:0] REF_TOP0_angle,
    output logic [BIT_DEPTH-1:0] REF_TOP1_angle,
    output logic [BIT_DEPTH-1:0] REF_TOP2_angle,
    output logic [BIT_DEPTH-1:0] REF_TOP3_angle,
    output logic [BIT_DEPTH-1:0] REF_TOP4_angle,
    output logic [BIT_DEPTH-1:0] REF_TOP5_angle,
    output logic [BIT_DEPTH-1:0] REF_TOP6_angle,
    output logic [BIT_DEPTH-1:0] REF_TOP7_angle,
    output logic [BIT_DEPTH-1:0] REF_LEFT0_angle,
    output logic [BIT_DEPTH-1:0] REF_LEFT1_angle,
    output logic [BIT_DEPTH-1:0] REF_LEFT2_angle,
    output logic [BIT_DEPTH-1:0] REF_LEFT3_angle,
    output logic [BIT_DEPTH-1:0] REF_LEFT4_angle,
    output logic [BIT_DEPTH-1:0] REF_LEFT5_angle,
    output logic [BIT_DEPTH-1:0] REF_LEFT6_angle,
    output logic [BIT_DEPTH-1:0] REF_LEFT7_angle,
    output logic [BIT_DEPTH-1:0] REF_TOP0_planar,
    output logic [BIT_DEPTH-1:0] REF_TOP1_planar,
    output logic [BIT_DEPTH-1:0] REF_TOP2_planar,
    output logic [BIT_DEPTH-1:0] REF_TOP3_planar,
    output logic [BIT_DEPTH-1:0] REF_TOP4_planar,
    output logic [BIT_DEPTH-1:0] REF_TOP5_planar,
    output logic [BIT_DEPTH-1:0] REF_TOP6_planar,
    output logic [BIT_DEPTH-1:0] REF_TOP7_planar,
    output logic [BIT_DEPTH-1:0] REF_LEFT0_planar,
    output logic [BIT_DEPTH-1:0] REF_LEFT1_planar,
    output logic [BIT_DEPTH-1:0] REF_LEFT2_planar,
    output logic [BIT_DEPTH-1:0] REF_LEFT3_planar,
    output logic [BIT_DEPTH-1:0] REF_LEFT4_planar,
    output logic [BIT_DEPTH-1:0] REF_LEFT5_planar,
    output logic [BIT_DEPTH-1:0] REF_LEFT6_planar,
    output logic [BIT_DEPTH-1:0] REF_LEFT7_planar
);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_DEPTH-1:0] r_cap [NUM_SAMPLES];
    logic                 r_top_av;
    logic                 r_left_av;
    logic                 r_corner_av;

    // Substituted reference set, registered in SUBST and consumed by the filters in FILT.
    logic [BIT_DEPTH-1:0] r_c;
    logic [BIT_DEPTH-1:0] r_t [NUM_SIDE];
    logic [BIT_DEPTH-1:0] r_l [NUM_SIDE];
    logic [BIT_DEPTH-1:0] w_c;
    logic [BIT_DEPTH-1:0] w_t [NUM_SIDE];
    logic [BIT_DEPTH-1:0] w_l [NUM_SIDE];

    // Filter taps; position 7 of each side passes through unfiltered.
    logic [BIT_DEPTH-1:0] w_tf [NUM_SIDE-1];
    logic [BIT_DEPTH-1:0] w_lf [NUM_SIDE-1];

    logic [BIT_DEPTH-1:0] r_ta [NUM_SIDE];
    logic [BIT_DEPTH-1:0] r_la [NUM_SIDE];
    logic [BIT_DEPTH-1:0] r_tp [NUM_SIDE];
    logic [BIT_DEPTH-1:0] r_lp [NUM_SIDE];

    logic w_start_ok;
    logic w_transfer;
    logic w_last;

    // start is only honoured while no block is in flight.
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_transfer = pix_valid && (r_state == ST_LOAD);
    assign w_last     = w_transfer && (r_cnt == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_next    = r_state;
        pix_ready = 1'b0;
        busy      = 1'b0;
        ref_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                if (w_last) w_next = ST_SUBST;
            end
            ST_SUBST: begin
                busy   = 1'b1;
                w_next = ST_FILT;
            end
            ST_FILT: begin
                busy   = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                ref_valid = 1'b1;
                if (start) w_next = ST_LOAD;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Sample counter: cleared on an accepted start, advances only on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start_ok) begin
            r_cnt <= '0;
        end else if (w_transfer) begin
            r_cnt <= w_last ? '0 : r_cnt + 5'd1;
        end
    end

    // Availability flags are frozen for the whole block at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_top_av    <= 1'b0;
            r_left_av   <= 1'b0;
            r_corner_av <= 1'b0;
        end else if (w_start_ok) begin
            r_top_av    <= top_avail;
            r_left_av   <= left_avail;
            r_corner_av <= corner_avail;
        end
    end

    // Capture every transferred sample; unavailable positions are overridden later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SAMPLES; i++) r_cap[i] <= '0;
        end else if (w_transfer) begin
            r_cap[r_cnt] <= pix_in;
        end
    end

    // Substitution: left first, then corner, then top; each rule reads only raw available samples
    // except top, which takes the already-substituted corner.
    always_comb begin
        w_c = r_cap[0];
        for (int i = 0; i < NUM_SIDE; i++) begin
            w_t[i] = r_cap[1 + i];
            w_l[i] = r_cap[1 + NUM_SIDE + i];
        end
        if (!r_top_av && !r_left_av && !r_corner_av) begin
            w_c = DEFAULT_VAL;
            for (int i = 0; i < NUM_SIDE; i++) begin
                w_t[i] = DEFAULT_VAL;
                w_l[i] = DEFAULT_VAL;
            end
        end else begin
            if (!r_left_av) begin
                for (int i = 0; i < NUM_SIDE; i++) w_l[i] = r_corner_av ? r_cap[0] : r_cap[1];
            end
            if (!r_corner_av) begin
                w_c = r_left_av ? r_cap[1 + NUM_SIDE] : r_cap[1];
            end
            if (!r_top_av) begin
                for (int i = 0; i < NUM_SIDE; i++) w_t[i] = w_c;
            end
        end
    end

    // Register the substituted set during SUBST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c <= '0;
            for (int i = 0; i < NUM_SIDE; i++) begin
                r_t[i] <= '0;
                r_l[i] <= '0;
            end
        end else if (r_state == ST_SUBST) begin
            r_c <= w_c;
            for (int i = 0; i < NUM_SIDE; i++) begin
                r_t[i] <= w_t[i];
                r_l[i] <= w_l[i];
            end
        end
    end

    // Position 0 of each side uses the corner as its outer neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SIDE - 1; gi++) begin : g_filt
            if (gi == 0) begin : g_first
                ref_filter3 u_top  (.i_a(r_c), .i_b(r_t[0]), .i_c(r_t[1]), .o_f(w_tf[0]));
                ref_filter3 u_left (.i_a(r_c), .i_b(r_l[0]), .i_c(r_l[1]), .o_f(w_lf[0]));
            end else begin : g_mid
                ref_filter3 u_top  (.i_a(r_t[gi-1]), .i_b(r_t[gi]), .i_c(r_t[gi+1]), .o_f(w_tf[gi]));
                ref_filter3 u_left (.i_a(r_l[gi-1]), .i_b(r_l[gi]), .i_c(r_l[gi+1]), .o_f(w_lf[gi]));
            end
        end
    endgenerate

    // Output sets load only in FILT and hold through DONE and the following LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SIDE; i++) begin
                r_ta[i] <= '0;
                r_la[i] <= '0;
                r_tp[i] <= '0;
                r_lp[i] <= '0;
            end
        end else if (r_state == ST_FILT) begin
            for (int i = 0; i < NUM_SIDE; i++) begin
                r_ta[i] <= r_t[i];
                r_la[i] <= r_l[i];
            end
            for (int i = 0; i < NUM_SIDE - 1; i++) begin
                r_tp[i] <= w_tf[i];
                r_lp[i] <= w_lf[i];
            end
            r_tp[NUM_SIDE-1] <= r_t[NUM_SIDE-1];
            r_lp[NUM_SIDE-1] <= r_l[NUM_SIDE-1];
        end
    end

    assign REF_TOP0_angle   = r_ta[0];
    assign REF_TOP1_angle   = r_ta[1];
    assign REF_TOP2_angle   = r_ta[2];
    assign REF_TOP3_angle   = r_ta[3];
    assign REF_TOP4_angle   = r_ta[4];
    assign REF_TOP5_angle   = r_ta[5];
    assign REF_TOP6_angle   = r_ta[6];
    assign REF_TOP7_angle   = r_ta[7];
    assign REF_LEFT0_angle  = r_la[0];
    assign REF_LEFT1_angle  = r_la[1];
    assign REF_LEFT2_angle  = r_la[2];
    assign REF_LEFT3_angle  = r_la[3];
    assign REF_LEFT4_angle  = r_la[4];
    assign REF_LEFT5_angle  = r_la[5];
    assign REF_LEFT6_angle  = r_la[6];
    assign REF_LEFT7_angle  = r_la[7];
    assign REF_TOP0_planar  = r_tp[0];
    assign REF_TOP1_planar  = r_tp[1];
    assign REF_TOP2_planar  = r_tp[2];
    assign REF_TOP3_planar  = r_tp[3];
    assign REF_TOP4_planar  = r_tp[4];
    assign REF_TOP5_planar  = r_tp[5];
    assign REF_TOP6_planar  = r_tp[6];
    assign REF_TOP7_planar  = r_tp[7];
    assign REF_LEFT0_planar = r_lp[0];
    assign REF_LEFT1_planar = r_lp[1];
    assign REF_LEFT2_planar = r_lp[2];
    assign REF_LEFT3_planar = r_lp[3];
    assign REF_LEFT4_planar = r_lp[4];
    assign REF_LEFT5_planar = r_lp[5];
    assign REF_LEFT6_planar = r_lp[6];
    assign REF_LEFT7_planar = r_lp[7];

endmodule

// File: tb/tb_ref_sample_prep.sv
// tb/tb_ref_sample_prep.sv - self-checking bench for ref_sample_prep
module tb_ref_sample_prep;

    typedef struct packed {
        logic              c_av;
        logic              t_av;
        logic              l_av;
        logic [16:0][7:0]  pix;
        logic [31:0][7:0]  expv;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       top_avail = 1'b0;
    logic       left_avail = 1'b0;
    logic       corner_avail = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic       busy;
    logic       ref_valid;
    logic [7:0] ta [8];
    logic [7:0] la [8];
    logic [7:0] tp [8];
    logic [7:0] lp [8];

    int total = 0;
    int bad   = 0;

    vec_t              tbl [4];
    logic [31:0][7:0]  prev_exp;
    logic              have_prev = 1'b0;

    always #5 clk = ~clk;

    ref_sample_prep dut (
        .clk(clk), .rst(rst), .start(start),
        .top_avail(top_avail), .left_avail(left_avail), .corner_avail(corner_avail),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .ref_valid(ref_valid),
        .REF_TOP0_angle(ta[0]), .REF_TOP1_angle(ta[1]), .REF_TOP2_angle(ta[2]), .REF_TOP3_angle(ta[3]),
        .REF_TOP4_angle(ta[4]), .REF_TOP5_angle(ta[5]), .REF_TOP6_angle(ta[6]), .REF_TOP7_angle(ta[7]),
        .REF_LEFT0_angle(la[0]), .REF_LEFT1_angle(la[1]), .REF_LEFT2_angle(la[2]), .REF_LEFT3_angle(la[3]),
        .REF_LEFT4_angle(la[4]), .REF_LEFT5_angle(la[5]), .REF_LEFT6_angle(la[6]), .REF_LEFT7_angle(la[7]),
        .REF_TOP0_planar(tp[0]), .REF_TOP1_planar(tp[1]), .REF_TOP2_planar(tp[2]), .REF_TOP3_planar(tp[3]),
        .REF_TOP4_planar(tp[4]), .REF_TOP5_planar(tp[5]), .REF_TOP6_planar(tp[6]), .REF_TOP7_planar(tp[7]),
        .REF_LEFT0_planar(lp[0]), .REF_LEFT1_planar(lp[1]), .REF_LEFT2_planar(lp[2]), .REF_LEFT3_planar(lp[3]),
        .REF_LEFT4_planar(lp[4]), .REF_LEFT5_planar(lp[5]), .REF_LEFT6_planar(lp[6]), .REF_LEFT7_planar(lp[7])
    );

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int get_out(input int k);
        if (k < 8)       return int'(ta[k]);
        else if (k < 16) return int'(la[k-8]);
        else if (k < 24) return int'(tp[k-16]);
        else             return int'(lp[k-24]);
    endfunction

    task automatic check_outs(input string tag, input logic [31:0][7:0] want);
        for (int k = 0; k < 32; k++) chk($sformatf("%s_out%0d", tag, k), get_out(k), int'(want[k]));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ref_valid"}, int'(ref_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_pix_ready"}, int'(pix_ready), 0);
        check_outs(tag, '0);
    endtask

    // Reference model: fills missing neighbour groups, then smooths each side with a [1 2 1] kernel.
    function automatic int smooth(input int a, input int b, input int c);
        return (a + 2 * b + c + 2) / 4;
    endfunction

    function automatic vec_t model(input vec_t v);
        int c;
        int t [8];
        int l [8];
        c = int'(v.pix[0]);
        for (int i = 0; i < 8; i++) begin
            t[i] = int'(v.pix[1 + i]);
            l[i] = int'(v.pix[9 + i]);
        end
        if (!v.c_av && !v.t_av && !v.l_av) begin
            c = 128;
            for (int i = 0; i < 8; i++) begin
                t[i] = 128;
                l[i] = 128;
            end
        end else begin
            if (!v.l_av) for (int i = 0; i < 8; i++) l[i] = v.c_av ? c : t[0];
            if (!v.c_av) c = v.l_av ? l[0] : t[0];
            if (!v.t_av) for (int i = 0; i < 8; i++) t[i] = c;
        end
        for (int i = 0; i < 8; i++) begin
            v.expv[i]      = 8'(t[i]);
            v.expv[8 + i]  = 8'(l[i]);
            v.expv[16 + i] = 8'((i == 7) ? t[7] : smooth((i == 0) ? c : t[i-1], t[i], t[i+1]));
            v.expv[24 + i] = 8'((i == 7) ? l[7] : smooth((i == 0) ? c : l[i-1], l[i], l[i+1]));
        end
        return v;
    endfunction

    // Drives one complete block: start, 17 transfers, then waits for ref_valid and checks outputs.
    task automatic run_block(input string tag, input vec_t v, input bit toggle, input bit pulse_start);
        int idx;
        int cyc;
        int n;
        logic rdy;
        logic vld;
        @(posedge clk); #1;
        start = 1'b1;
        top_avail = v.t_av;
        left_avail = v.l_av;
        corner_avail = v.c_av;
        @(posedge clk); #1;
        start = 1'b0;
        top_avail = ~v.t_av;
        left_avail = ~v.l_av;
        corner_avail = ~v.c_av;
        chk({tag, "_ready_in_load"}, int'(pix_ready), 1);
        if (have_prev) check_outs({tag, "_hold"}, prev_exp);
        idx = 0;
        cyc = 0;
        while (idx < 17 && cyc < 200) begin
            pix_in = v.pix[idx];
            pix_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            start = pulse_start && (cyc == 9);
            rdy = pix_ready;
            vld = pix_valid;
            @(posedge clk); #1;
            if (rdy && vld) idx++;
            cyc++;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        chk({tag, "_transfers"}, idx, 17);
        chk({tag, "_busy_after_last"}, int'(busy), 1);
        chk({tag, "_ready_after_last"}, int'(pix_ready), 0);
        n = 0;
        while (!ref_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 2);
        chk({tag, "_busy_done"}, int'(busy), 0);
        check_outs(tag, v.expv);
        prev_exp = v.expv;
        have_prev = 1'b1;
    endtask

    initial begin
        // Directed table: expected values written from the documented test cases.
        tbl[0] = '0;
        tbl[0].c_av = 1'b1; tbl[0].t_av = 1'b1; tbl[0].l_av = 1'b1;
        tbl[0].pix[0] = 8'd100;
        for (int i = 0; i < 8; i++) begin
            tbl[0].pix[1 + i]  = 8'(100 + 10 * i);
            tbl[0].pix[9 + i]  = 8'(90 - 10 * i);
            tbl[0].expv[i]      = 8'(100 + 10 * i);
            tbl[0].expv[8 + i]  = 8'(90 - 10 * i);
            tbl[0].expv[16 + i] = (i == 0) ? 8'd103 : 8'(100 + 10 * i);
            tbl[0].expv[24 + i] = 8'(90 - 10 * i);
        end

        tbl[1] = '0;
        for (int i = 0; i < 17; i++) tbl[1].pix[i] = 8'(i * 37 + 5);
        for (int k = 0; k < 32; k++) tbl[1].expv[k] = 8'd128;

        tbl[2] = '0;
        tbl[2].t_av = 1'b1;
        tbl[2].pix[0] = 8'd7;
        for (int i = 0; i < 8; i++) begin
            tbl[2].pix[1 + i]  = 8'(50 + 10 * i);
            tbl[2].pix[9 + i]  = 8'(200 + i);
            tbl[2].expv[i]      = 8'(50 + 10 * i);
            tbl[2].expv[8 + i]  = 8'd50;
            tbl[2].expv[16 + i] = (i == 0) ? 8'd53 : 8'(50 + 10 * i);
            tbl[2].expv[24 + i] = 8'd50;
        end

        tbl[3] = '0;
        tbl[3].c_av = 1'b1; tbl[3].l_av = 1'b1;
        tbl[3].pix[0] = 8'd200;
        for (int i = 0; i < 8; i++) begin
            tbl[3].pix[1 + i]  = 8'(3 + i);
            tbl[3].pix[9 + i]  = 8'(10 + 10 * i);
            tbl[3].expv[i]      = 8'd200;
            tbl[3].expv[8 + i]  = 8'(10 + 10 * i);
            tbl[3].expv[16 + i] = 8'd200;
            tbl[3].expv[24 + i] = (i == 0) ? 8'd60 : 8'(10 + 10 * i);
        end

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        for (int t = 0; t < 4; t++) run_block($sformatf("tbl%0d", t), tbl[t], 1'b0, 1'b0);

        // Stalled stream with a stray start mid-load.
        run_block("stall", tbl[0], 1'b1, 1'b1);

        // Reset after 9 samples discards the partial block.
        @(posedge clk); #1;
        start = 1'b1; top_avail = 1'b1; left_avail = 1'b1; corner_avail = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pix_in = 8'(i + 1);
            pix_valid = 1'b1;
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        rst = 1'b1;
        #2;
        check_reset_state("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        have_prev = 1'b0;
        run_block("after_rst", tbl[2], 1'b0, 1'b0);

        // Random blocks against the reference model.
        for (int r = 0; r < 20; r++) begin
            vec_t v;
            v = '0;
            v.c_av = 1'($urandom);
            v.t_av = 1'($urandom);
            v.l_av = 1'($urandom);
            for (int i = 0; i < 17; i++) v.pix[i] = 8'($urandom);
            v = model(v);
            run_block($sformatf("rnd%0d", r), v, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got=expired want=finished");
        $fatal(1, "timeout");
    end

endmodule
